// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//  Client request/response bundle plus the pins of the shared multiplier.
//  master : client side + multiplier (drives requests, operands results back)
//  slave  : arbiter side
//  req_valid/req_ready/req_a/req_b : per-requester issue handshake, packed operands
//  rsp_valid/rsp_data              : one-cycle result pulse to owning requester
//  mul_a/mul_b/mul_valid_in        : operands and strobe toward the multiplier
//  mul_out/mul_valid_out           : multiplier result and valid
interface mult_share_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [RESULT_WIDTH-1:0]       rsp_data;
  logic [DATA_WIDTH-1:0]         mul_a;
  logic [DATA_WIDTH-1:0]         mul_b;
  logic                          mul_valid_in;
  logic [RESULT_WIDTH-1:0]       mul_out;
  logic                          mul_valid_out;

  modport master (
    output req_valid, req_a, req_b, mul_out, mul_valid_out,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_valid_in
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_out, mul_valid_out,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b, mul_valid_in
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//  Shares one pipelined multiplier among NUM_REQ requesters: round-robin
//  grant (one issue per cycle), ID tag pipe aligned with the multiplier
//  latency, and result routed back to the issuing requester.
//  Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : request handshake, response pulse, multiplier pins
//   hold_i       : stop granting and drain in-flight operations
//   idle_o       : held and fully drained
//   err_o        : sticky, multiplier valid disagreed with the tag pipe
//   grant_cnt_o  : per-requester 16-bit grant counters (MULT_ARB_STATS_EN only)
//  Optional feature macro: MULT_ARB_STATS_EN
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned MUL_LATENCY  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus,
  input  logic                 hold_i,
  output logic                 idle_o,
  output logic                 err_o
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt_o
`endif
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    mul_valid_in_q, mul_valid_in_d;
  logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [ID_W-1:0]         issue_id_q, issue_id_d;
  tag_t [MUL_LATENCY-1:0]  tag_q;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [RESULT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    err_q, err_d;
  logic                    idle_q;
  logic [NUM_REQ-1:0]      grant_c;
  logic [ID_W-1:0]         cand;
  logic                    found;
  logic                    busy;
  tag_t                    tail;

  // Cyclic increment of a requester index.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     k);
    return ID_W'((32'(base) + k) % NUM_REQ);
  endfunction

  assign tail = tag_q[MUL_LATENCY-1];

  // Anything issued and not yet returned by the multiplier.
  always_comb begin
    busy = mul_valid_in_q;
    for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
      busy = busy | tag_q[i].v;
    end
  end

  // Next state, round-robin grant, issue selection, response routing.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_c        = '0;
    cand           = '0;
    found          = 1'b0;
    issue_id_d     = issue_id_q;
    mul_valid_in_d = 1'b0;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    rsp_valid_d    = '0;
    rsp_data_d     = rsp_data_q;
    err_d          = err_q | (tail.v != bus.mul_valid_out);

    unique case (state_q)
      S_RUN:   if (hold_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!hold_i)    state_d = S_RUN;
        else if (!busy) state_d = S_HOLD;
      end
      S_HOLD:  if (!hold_i) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    // rst_n gate keeps the grant quiet while the block is held in reset.
    if (rst_n && (state_q == S_RUN) && !hold_i) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = wrap_add(rr_ptr_q, k);
        if (!found && bus.req_valid[cand]) begin
          found      = 1'b1;
          issue_id_d = cand;
        end
      end
    end

    if (found) begin
      grant_c[issue_id_d] = 1'b1;
      rr_ptr_d            = wrap_add(issue_id_d, 1);
      mul_valid_in_d      = 1'b1;
    end

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        mul_a_d = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        mul_b_d = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // A result is only delivered when the tag and the multiplier agree.
    if (tail.v && bus.mul_valid_out) begin
      rsp_valid_d[tail.id] = 1'b1;
      rsp_data_d           = bus.mul_out;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      rr_ptr_q       <= '0;
      mul_valid_in_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      issue_id_q     <= '0;
      tag_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      err_q          <= 1'b0;
      idle_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      mul_valid_in_q <= mul_valid_in_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      issue_id_q     <= issue_id_d;
      tag_q[0]       <= {mul_valid_in_q, issue_id_q};
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      err_q          <= err_d;
      idle_q         <= (state_d == S_HOLD);
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_q;

  // Free-running per-requester grant counters, wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_c[i]) grant_cnt_q[i] <= grant_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

  assign bus.req_ready    = grant_c;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.mul_valid_in = mul_valid_in_q;
  assign idle_o           = idle_q;
  assign err_o            = err_q;
endmodule
